arbiter_priority_4: RTL
=======================

Name: arbiter_priority_4

Overview:
- Four-requester arbiter that shares one resource (bus or port) between requesters 0..3.
- Arbitration uses either fixed high-priority order (index 3 highest, same convention as the 4-2 high priority encoder) or rotating round-robin order.
- Each grant is held until the owner drops its request or a hold-time limit expires.
- Sits in front of a shared datapath; Grant_Out drives the datapath select/enables.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held; 0 means unlimited.
- COUNT_WIDTH, 4, width of the hold counter; must satisfy 2^COUNT_WIDTH > HOLD_MAX.

Ports:
- Clock_In  input  1  single system clock, rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Request_In  input  4  request vector; bit i is requester i.
- Mode_In  input  1  0 = fixed priority (3 > 2 > 1 > 0), 1 = round-robin.
- Grant_Out  output  4  one-hot grant vector; all zero when no grant.
- Grant_Index_Out  output  2  binary index of the current grant; 0 when no grant.
- Grant_Valid_Out  output  1  high while a grant is active.
- Timeout_Out  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (async assert, sync release):
  - Grant_Out=0, Grant_Index_Out=0, Grant_Valid_Out=0, Timeout_Out=0.
  - State=IDLE, hold counter=0, Last_Grant=3, Timeout_Mask=0.
- FSM states: IDLE, GRANT.
- IDLE, arbitration:
  - Arbitration runs on every edge in IDLE. Eligible = Request_In & ~Timeout_Mask.
  - If Eligible is zero: stay in IDLE, outputs stay zero, Timeout_Mask clears.
  - Otherwise select winner W:
    - Mode_In=0: highest set index of Eligible.
    - Mode_In=1: first set bit searching Last_Grant+1, +2, +3, +4 (mod 4). Reset value 3 gives search order 0,1,2,3.
  - On the edge: Grant_Out = one-hot(W), Grant_Index_Out = W, Grant_Valid_Out = 1, Last_Grant = W, counter = 1, Timeout_Mask = 0, go to GRANT.
  - Latency: request seen at edge N → grant visible after edge N.
  - Mode_In is sampled only at arbitration; changing it during GRANT has no effect on the current grant.
- GRANT:
  - If Request_In[Grant_Index_Out]=0 (release): clear grant outputs on the next edge and go to IDLE.
  - Else if HOLD_MAX != 0 and counter == HOLD_MAX (timeout):
    - Clear grant outputs on the next edge and pulse Timeout_Out for that cycle.
    - Set Timeout_Mask = one-hot(Grant_Index_Out); go to IDLE.
  - Else: counter increments and the grant holds.
  - Release takes precedence over timeout when both apply on the same edge; no Timeout_Out in that case.
- Turnaround: every grant ends with at least one cycle of Grant_Out=0 (the IDLE cycle). Back-to-back grants to different requesters are therefore separated by exactly one idle cycle.
- Timeout_Mask:
  - Excludes the timed-out requester from exactly one arbitration, in both modes.
  - Clears after that arbitration, whether or not anyone won.
- Requests that rise or fall during GRANT for non-owners are ignored until the next IDLE.
- Grant_Out is always one-hot or zero. Grant_Valid_Out == |Grant_Out.
- Reset mid-grant: outputs clear immediately (asynchronously). State returns to IDLE and Last_Grant returns to 3.
- Counter never exceeds HOLD_MAX. With HOLD_MAX=0 it saturates at its maximum value and no timeout occurs.

Test Plan:
- Reset: Reset_In=1 with Request_In=4'b1111 → all outputs 0. Release reset, Mode_In=0 → next edge Grant_Out=4'b1000, Grant_Index_Out=3, Grant_Valid_Out=1.
- Fixed priority: Request_In=4'b0110 held 3 cycles, then 4'b0100→4'b0000 → Grant_Out=4'b0100 for 3 cycles, 1 cycle 0, then 4'b0010, then 0 after request 1 drops.
- Round-robin: Mode_In=1, Request_In=4'b1111, each owner drops its request for one cycle after 2 granted cycles → grant order 0,1,2,3,0 with one idle cycle between grants.
- Timeout: HOLD_MAX=8, Mode_In=0, Request_In=4'b1001 held constant:
  - Grant_Out=4'b1000 for exactly 8 cycles, then Timeout_Out=1 for 1 cycle with Grant_Out=0.
  - Next grant goes to requester 0 (4'b0001) because requester 3 is masked.
  - After requester 0 releases, requester 3 is granted again.
- Release vs timeout collision: requester 3 drops its request on the edge where counter==8 → grant clears, Timeout_Out stays 0, no mask (requester 3 wins next arbitration if it re-requests).
- Async reset mid-grant: assert Reset_In between clock edges during GRANT → Grant_Out=0 immediately. After release with Mode_In=1, Request_In=4'b1010 → Grant_Out=4'b0010 (Last_Grant back to 3).

Source files
------------

// File: rtl/arbiter_priority_4.sv
// rtl/arbiter_priority_4.sv - four-requester fixed/round-robin arbiter with hold-time limit
// Grants are registered; a timed-out owner sits out exactly one arbitration.
module arbiter_priority_4 #(
  parameter int HOLD_MAX    = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic [3:0] Request_In,
  input  logic       Mode_In,
  output logic [3:0] Grant_Out,
  output logic [1:0] Grant_Index_Out,
  output logic       Grant_Valid_Out,
  output logic       Timeout_Out
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [COUNT_WIDTH-1:0] HOLD_MAX_C = COUNT_WIDTH'(HOLD_MAX);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

  state_t                 state_q, state_d;
  logic [3:0]             grant_q, grant_d;
  logic [1:0]             index_q, index_d;
  logic                   timeout_q, timeout_d;
  logic [1:0]             last_q, last_d;
  logic [3:0]             mask_q, mask_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0] eligible;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      index_q   <= 2'd0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;
      mask_q    <= 4'b0000;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    eligible  = Request_In & ~mask_q;
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    if (!Mode_In) begin
      // ascending scan: the highest set index is assigned last and wins
      for (int i = 0; i < 4; i++) begin
        if (eligible[i]) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end else begin
      // descending offset scan: offset 1 after the last owner is assigned last and wins
      for (int i = 4; i >= 1; i--) begin
        cand = last_q + 2'(i);
        if (eligible[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end

    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        mask_d  = 4'b0000;
        grant_d = 4'b0000;
        index_d = 2'd0;
        if (win_found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win_idx;
          index_d = win_idx;
          last_d  = win_idx;
          cnt_d   = COUNT_WIDTH'(1);
        end
      end
      GRANT: begin
        if (!Request_In[index_q]) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          index_d = 2'd0;
          cnt_d   = '0;
        end else if ((HOLD_MAX != 0) && (cnt_q == HOLD_MAX_C)) begin
          state_d   = IDLE;
          grant_d   = 4'b0000;
          index_d   = 2'd0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          mask_d    = grant_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        index_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    Grant_Out       = grant_q;
    Grant_Index_Out = index_q;
    Grant_Valid_Out = |grant_q;
    Timeout_Out     = timeout_q;
  end

endmodule
